// File: rtl/gt_victim_cache.sv
// Fully-associative victim cache behind L1: per-cycle lookup, FIFO replacement,
// registered outputs with push-out of the oldest line when a full cache takes an insert.

module gt_victim_cache_entry #(
  parameter int TAG_W     = 27,
  parameter int LINE_BITS = 256
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 we,
  input  logic [TAG_W-1:0]     wTag,
  input  logic [LINE_BITS-1:0] wData,
  input  logic [TAG_W-1:0]     lkTag,
  output logic                 valid,
  output logic [TAG_W-1:0]     tag,
  output logic [LINE_BITS-1:0] data,
  output logic                 match
);
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wTag;
      data  <= wData;
    end
  end

  assign match = valid && (tag == lkTag);
endmodule

module gt_victim_cache #(
  parameter int ENTRIES   = 4,
  parameter int LINE_BITS = 256,
  parameter int ADDR_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [LINE_BITS-1:0] memDataIn,
  input  logic                 insert,
  input  logic [ADDR_BITS-1:0] nextAddr,
  output logic [LINE_BITS-1:0] memDataOut,
  output logic [7:0]           dataReturn,
  output logic                 hit,
  output logic [LINE_BITS-1:0] toMemData,
  output logic                 toMemValid,
  output logic [ADDR_BITS-1:0] lineAddr
);
  localparam int OFS   = $clog2(LINE_BITS / 8);
  localparam int TAG_W = ADDR_BITS - OFS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  logic [TAG_W-1:0] lkTag;
  logic [OFS-1:0]   offset;
  assign lkTag  = nextAddr[ADDR_BITS-1:OFS];
  assign offset = nextAddr[OFS-1:0];

  logic [ENTRIES-1:0]                eValid, eMatch, eWe;
  logic [ENTRIES-1:0][TAG_W-1:0]     eTag;
  logic [ENTRIES-1:0][LINE_BITS-1:0] eData;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    gt_victim_cache_entry #(.TAG_W(TAG_W), .LINE_BITS(LINE_BITS)) u_entry (
      .CLK   (CLK),
      .RST   (RST),
      .we    (eWe[i]),
      .wTag  (lkTag),
      .wData (memDataIn),
      .lkTag (lkTag),
      .valid (eValid[i]),
      .tag   (eTag[i]),
      .data  (eData[i]),
      .match (eMatch[i])
    );
  end

  logic [IDX_W-1:0] head;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0]     hitIdx, freeIdx, wIdx;
  logic                 anyHit, full, pushOut;
  logic [LINE_BITS-1:0] hitData;
  logic [7:0]           hitByte;

  always_comb begin
    hitIdx  = '0;
    freeIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (eMatch[i])  hitIdx  = IDX_W'(i);
      if (!eValid[i]) freeIdx = IDX_W'(i);
    end
  end

  assign anyHit  = |eMatch;
  assign full    = (count == FULL_CNT);
  assign hitData = eData[hitIdx];
  assign hitByte = hitData[{offset, 3'b000} +: 8];

  // Priority: in-place overwrite on tag match, then a free slot, else replace the FIFO head.
  always_comb begin
    wIdx    = head;
    pushOut = 1'b0;
    if (anyHit)     wIdx = hitIdx;
    else if (!full) wIdx = freeIdx;
    else            pushOut = insert;
    eWe = '0;
    if (insert) eWe[wIdx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head       <= '0;
      count      <= '0;
      hit        <= 1'b0;
      memDataOut <= '0;
      dataReturn <= '0;
      toMemValid <= 1'b0;
      toMemData  <= '0;
      lineAddr   <= '0;
    end else begin
      if (insert && !anyHit) begin
        if (full) head  <= head + IDX_W'(1);
        else      count <= count + CNT_W'(1);
      end
      hit        <= anyHit;
      memDataOut <= anyHit ? hitData : '0;
      dataReturn <= anyHit ? hitByte : 8'h00;
      toMemValid <= pushOut;
      toMemData  <= pushOut ? eData[head] : '0;
      lineAddr   <= pushOut ? {eTag[head], {OFS{1'b0}}} : '0;
    end
  end
endmodule

// File: tb/tb_gt_victim_cache.sv
// Directed bench for gt_victim_cache: fill, FIFO push-out, lookup, overwrite, reset.

module tb_gt_victim_cache;
  localparam logic [255:0] P =
    256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [255:0] memDataIn = '0;
  logic         insert = 1'b0;
  logic [31:0]  nextAddr = '0;
  logic [255:0] memDataOut, toMemData;
  logic [7:0]   dataReturn;
  logic         hit, toMemValid;
  logic [31:0]  lineAddr;

  int checks = 0;
  int errors = 0;

  gt_victim_cache dut (
    .CLK        (CLK),
    .RST        (RST),
    .memDataIn  (memDataIn),
    .insert     (insert),
    .nextAddr   (nextAddr),
    .memDataOut (memDataOut),
    .dataReturn (dataReturn),
    .hit        (hit),
    .toMemData  (toMemData),
    .toMemValid (toMemValid),
    .lineAddr   (lineAddr)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of stimulus; outputs are looked at 1 time unit after the edge.
  task automatic step(input logic rst, input logic ins, input logic [31:0] a, input logic [255:0] d);
    RST = rst; insert = ins; nextAddr = a; memDataIn = d;
    @(posedge CLK);
    #1;
    RST = 1'b0; insert = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 32'h0, '0);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", hit); end
    checks++; if (toMemValid !== 1'b0) begin errors++; $display("FAIL reset_tmv got %b exp 0", toMemValid); end
    checks++; if (memDataOut !== '0 || toMemData !== '0) begin errors++; $display("FAIL reset_data got %h / %h exp 0", memDataOut, toMemData); end
    checks++; if (dataReturn !== 8'h00 || lineAddr !== 32'h0) begin errors++; $display("FAIL reset_misc got %h / %h exp 0", dataReturn, lineAddr); end
  endtask

  task automatic test_fill;
    logic [31:0] addrs [4] = '{32'h01000001, 32'h02000002, 32'h03000003, 32'h04000004};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, addrs[i], P);
      checks++; if (hit !== 1'b0 || toMemValid !== 1'b0) begin
        errors++; $display("FAIL fill_%0d got hit=%b tmv=%b exp 0 0", i, hit, toMemValid);
      end
    end
  endtask

  task automatic test_evict;
    step(1'b0, 1'b1, 32'h05000005, P);
    checks++; if (toMemValid !== 1'b1) begin errors++; $display("FAIL evict_tmv got %b exp 1", toMemValid); end
    checks++; if (lineAddr !== 32'h01000000) begin errors++; $display("FAIL evict_addr got %h exp 01000000", lineAddr); end
    checks++; if (toMemData !== P) begin errors++; $display("FAIL evict_data got %h exp %h", toMemData, P); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evict_hit got %b exp 0", hit); end
  endtask

  task automatic test_read;
    step(1'b0, 1'b0, 32'h03000003, '0);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL read_hit got %b exp 1", hit); end
    checks++; if (memDataOut !== P) begin errors++; $display("FAIL read_line got %h exp %h", memDataOut, P); end
    checks++; if (dataReturn !== 8'h11) begin errors++; $display("FAIL read_byte got %h exp 11", dataReturn); end
    checks++; if (toMemValid !== 1'b0) begin errors++; $display("FAIL read_tmv got %b exp 0", toMemValid); end
    step(1'b0, 1'b0, 32'h07000007, '0);
    checks++; if (hit !== 1'b0 || dataReturn !== 8'h00 || memDataOut !== '0) begin
      errors++; $display("FAIL read_miss got hit=%b byte=%h line=%h exp 0", hit, dataReturn, memDataOut);
    end
  endtask

  task automatic test_evict_order;
    step(1'b0, 1'b0, 32'h01000001, '0);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evicted_gone got %b exp 0", hit); end
    step(1'b0, 1'b1, 32'h06000000, P);
    checks++; if (toMemValid !== 1'b1 || lineAddr !== 32'h02000000) begin
      errors++; $display("FAIL evict2 got tmv=%b addr=%h exp 1 02000000", toMemValid, lineAddr);
    end
    step(1'b0, 1'b0, 32'h0, '0);
    checks++; if (toMemValid !== 1'b0 || lineAddr !== 32'h0 || toMemData !== '0) begin
      errors++; $display("FAIL idle_push got tmv=%b addr=%h data=%h exp 0", toMemValid, lineAddr, toMemData);
    end
  endtask

  task automatic test_overwrite;
    step(1'b0, 1'b1, 32'h03000010, '0);
    checks++; if (toMemValid !== 1'b0) begin errors++; $display("FAIL ovw_tmv got %b exp 0", toMemValid); end
    // Lookup in the overwrite cycle sees the old line; byte 16 of P is 8'h88.
    checks++; if (hit !== 1'b1 || memDataOut !== P || dataReturn !== 8'h88) begin
      errors++; $display("FAIL ovw_pre got hit=%b byte=%h exp 1 88", hit, dataReturn);
    end
    step(1'b0, 1'b0, 32'h03000003, '0);
    checks++; if (hit !== 1'b1 || dataReturn !== 8'h00 || memDataOut !== '0) begin
      errors++; $display("FAIL ovw_post got hit=%b byte=%h line=%h exp 1 00 0", hit, dataReturn, memDataOut);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b1, 32'h04000004, P);
    checks++; if (hit !== 1'b0 || toMemValid !== 1'b0 || memDataOut !== '0 || toMemData !== '0 || lineAddr !== 32'h0 || dataReturn !== 8'h00) begin
      errors++; $display("FAIL rstmid_out got hit=%b tmv=%b exp 0 0", hit, toMemValid);
    end
    step(1'b0, 1'b0, 32'h04000004, '0);
    checks++; if (hit !== 1'b0 || memDataOut !== '0 || dataReturn !== 8'h00 || toMemValid !== 1'b0) begin
      errors++; $display("FAIL rstmid_read got hit=%b byte=%h exp 0 0", hit, dataReturn);
    end
  endtask

  // Nine back-to-back inserts into an empty cache: inserts 4..8 push out lines 0..4,
  // so the head pointer wraps past the last slot.
  task automatic test_back_to_back;
    logic [31:0]  a;
    logic [255:0] d;
    for (int i = 0; i < 9; i++) begin
      a = 32'h0000_1000 + 32'(i) * 32'h20 + 32'(i);
      d = {8{32'(i)}};
      step(1'b0, 1'b1, a, d);
      checks++;
      if (i < 4) begin
        if (toMemValid !== 1'b0) begin errors++; $display("FAIL b2b_nopush_%0d got %b exp 0", i, toMemValid); end
      end else begin
        if (toMemValid !== 1'b1 || lineAddr !== 32'h0000_1000 + 32'(i - 4) * 32'h20 || toMemData !== {8{32'(i - 4)}}) begin
          errors++; $display("FAIL b2b_push_%0d got tmv=%b addr=%h exp 1 %h", i, toMemValid, lineAddr, 32'h0000_1000 + 32'(i - 4) * 32'h20);
        end
      end
    end
    step(1'b0, 1'b0, 32'h0000_1000, '0);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL b2b_old got %b exp 0", hit); end
    step(1'b0, 1'b0, 32'h0000_1100, '0);
    checks++; if (hit !== 1'b1 || dataReturn !== 8'h08) begin
      errors++; $display("FAIL b2b_new got hit=%b byte=%h exp 1 08", hit, dataReturn);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset;
    test_fill;
    test_evict;
    test_read;
    test_evict_order;
    test_overwrite;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
